// File: rtl/plic_pkg.sv
// Shared constants for the interrupt controller: register offsets and claim-ID width.
package plic_pkg;

   localparam int PLIC_ID_W = 5;

   localparam logic [3:0] PLIC_PENDING = 4'h0;
   localparam logic [3:0] PLIC_ENABLE  = 4'h4;
   localparam logic [3:0] PLIC_CLAIM   = 4'h8;
   localparam logic [3:0] PLIC_TRIGGER = 4'hC;

   localparam logic [PLIC_ID_W-1:0] PLIC_ID_NONE = '0;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: turns a raw request into pending/in-service state.
// Edge mode records rising edges (even while in service); level mode
// re-pends whenever the line is high and the source is not in service.
module plic_gateway
   import plic_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic int_i,
   input  logic edge_mode,
   input  logic claim,
   input  logic complete,
   output logic pending,
   output logic in_service
);

   logic int_q;
   logic set_evt;

   assign set_evt = edge_mode ? (int_i & ~int_q) : (int_i & ~in_service);

   // Sample the request line; a set event in the claim cycle keeps pending high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_q      <= 1'b0;
         pending    <= 1'b0;
         in_service <= 1'b0;
      end else begin
         int_q      <= int_i;
         pending    <= set_evt | (pending & ~claim);
         in_service <= claim | (in_service & ~complete);
      end
   end

endmodule

// File: rtl/plic_ctrl.sv
// Registered interrupt controller: register decode, fixed lowest-index
// priority, claim/complete handshake and the registered request to the core.
module plic_ctrl
   import plic_pkg::*;
#(
   parameter int NUM_SRC = 16,
   parameter int ID_W    = PLIC_ID_W
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] int_i,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [3:0]         addr_i,
   input  logic [31:0]        wdata_i,
   output logic [31:0]        rdata_o,
   output logic               int_o
);

   logic [NUM_SRC-1:0] enable;
   logic [NUM_SRC-1:0] trigger;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] in_service;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] claim_vec;
   logic [NUM_SRC-1:0] complete_vec;
   logic [ID_W-1:0]    winner_id;
   logic [3:0]         reg_addr;
   logic               claim_rd;
   logic               complete_wr;
   logic               unused_bits;

   // Lowest set index wins; result is index+1, or none when nothing is set.
   function automatic logic [ID_W-1:0] pick_id(input logic [NUM_SRC-1:0] v);
      pick_id = PLIC_ID_NONE;
      for (int n = NUM_SRC - 1; n >= 0; n--) begin
         if (v[n]) pick_id = ID_W'(n + 1);
      end
   endfunction

   assign reg_addr    = {addr_i[3:2], 2'b00};
   assign claim_rd    = re_i && (reg_addr == PLIC_CLAIM);
   assign complete_wr = we_i && (reg_addr == PLIC_CLAIM);
   assign elig        = pending & enable & ~in_service;
   assign winner_id   = pick_id(elig);
   assign unused_bits = ^{addr_i[1:0], wdata_i[31:NUM_SRC]};

   // A complete for an ID that is out of range or not in service matches no
   // source, or matches one whose in_service is already clear.
   for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
      assign claim_vec[n]    = claim_rd && (winner_id == ID_W'(n + 1));
      assign complete_vec[n] = complete_wr && (wdata_i[ID_W-1:0] == ID_W'(n + 1));

      plic_gateway u_gw (
         .clk        (clk),
         .rst        (rst),
         .int_i      (int_i[n]),
         .edge_mode  (trigger[n]),
         .claim      (claim_vec[n]),
         .complete   (complete_vec[n]),
         .pending    (pending[n]),
         .in_service (in_service[n])
      );
   end

   // Software-writable ENABLE and TRIGGER; new values apply from the next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable  <= '0;
         trigger <= '0;
      end else if (we_i) begin
         if (reg_addr == PLIC_ENABLE)  enable  <= wdata_i[NUM_SRC-1:0];
         if (reg_addr == PLIC_TRIGGER) trigger <= wdata_i[NUM_SRC-1:0];
      end
   end

   // Read data is captured from pre-write state and held until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_o <= '0;
      end else if (re_i) begin
         case (reg_addr)
            PLIC_PENDING: rdata_o <= 32'(pending);
            PLIC_ENABLE:  rdata_o <= 32'(enable);
            PLIC_CLAIM:   rdata_o <= 32'(winner_id);
            PLIC_TRIGGER: rdata_o <= 32'(trigger);
            default:      rdata_o <= '0;
         endcase
      end
   end

   // Registered request to the core, one cycle behind eligibility.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) int_o <= 1'b0;
      else     int_o <= |elig;
   end

endmodule
